// File: rtl/fpu_reg_stack.sv
// x87-style register stack: circular register file addressed relative to top, with tag word and fault flags.
// Define FPU_STACK_TAGCLASS_EN to classify written values (zero/special/valid) into the tag word.
module fpu_reg_stack #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDXW  = $clog2(DEPTH),
    parameter logic [79:0] INDEF = 80'hFFFF_C000000000000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [IDXW-1:0]    cmd_idx,
    input  logic [WIDTH-1:0]   cmd_data,
    output logic               resp_valid,
    output logic [WIDTH-1:0]   resp_data,
    output logic               resp_fault,
    output logic [IDXW-1:0]    top,
    output logic [2*DEPTH-1:0] tag_word,
    output logic               c1,
    output logic               sf
);

    typedef enum logic [1:0] {IDLE, EXEC, XCHG2, RESP} state_t;
    typedef enum logic [2:0] {
        OP_NOP, OP_PUSH, OP_POP, OP_READ, OP_WRITE, OP_XCHG, OP_FREE, OP_RSVD
    } op_t;

    localparam logic [1:0]       TAG_VALID = 2'b00;
    localparam logic [1:0]       TAG_EMPTY = 2'b11;
    localparam logic [WIDTH-1:0] INDEF_W   = WIDTH'(INDEF);

    state_t           state;
    op_t              op_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] tmp_q;
    logic             xchg_do_q;

    logic [WIDTH-1:0] regs [DEPTH];

    logic [IDXW-1:0]  slot0, sloti, slotp;
    logic             empty0, emptyi, emptyp;
    logic [WIDTH-1:0] rd0, rdi;

    logic             we;
    logic [IDXW-1:0]  waddr;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       wtag;
    logic             fault;
    logic             xchg_do;

    assign slot0  = top;
    assign sloti  = top + idx_q;
    assign slotp  = top - IDXW'(1);
    assign empty0 = (tag_word[{slot0, 1'b0} +: 2] == TAG_EMPTY);
    assign emptyi = (tag_word[{sloti, 1'b0} +: 2] == TAG_EMPTY);
    assign emptyp = (tag_word[{slotp, 1'b0} +: 2] == TAG_EMPTY);
    assign rd0    = regs[slot0];
    assign rdi    = regs[sloti];

`ifdef FPU_STACK_TAGCLASS_EN
    // 80-bit layout sits in the top bits: sign, 15-bit exponent, 64-bit mantissa.
    function automatic logic [1:0] tag_class(input logic [WIDTH-1:0] v);
        logic [14:0] e;
        logic [63:0] m;
        e = v[WIDTH-2 -: 15];
        m = v[WIDTH-17 -: 64];
        if (e == '0 && m == '0)
            return 2'b01;
        else if (e == '1 || e == '0)
            return 2'b10;
        else
            return TAG_VALID;
    endfunction

    assign wtag = tag_class(wdata);
`else
    assign wtag = TAG_VALID;
`endif

    // Single write port: EXEC performs the primary write, XCHG2 the second half of an exchange.
    always_comb begin
        we      = 1'b0;
        waddr   = slot0;
        wdata   = data_q;
        fault   = 1'b0;
        xchg_do = !empty0 && !emptyi;
        if (state == EXEC) begin
            case (op_q)
                OP_PUSH: begin
                    fault = !emptyp;
                    we    = emptyp;
                    waddr = slotp;
                end
                OP_POP:  fault = empty0;
                OP_READ: fault = emptyi;
                OP_WRITE: begin
                    we    = 1'b1;
                    waddr = sloti;
                end
                OP_XCHG: begin
                    fault = (idx_q != '0) && !xchg_do;
                    we    = xchg_do;
                    wdata = rdi;
                end
                default: ;
            endcase
        end else if (state == XCHG2) begin
            we    = xchg_do_q;
            waddr = sloti;
            wdata = tmp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            regs[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= OP_NOP;
            idx_q      <= '0;
            data_q     <= '0;
            tmp_q      <= '0;
            xchg_do_q  <= 1'b0;
            top        <= '0;
            tag_word   <= '1;
            sf         <= 1'b0;
            c1         <= 1'b0;
            cmd_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (we)
                tag_word[{waddr, 1'b0} +: 2] <= wtag;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_t'(cmd_op);
                        idx_q     <= cmd_idx;
                        data_q    <= cmd_data;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_PUSH: begin
                            if (!fault)
                                top <= slotp;
                        end
                        OP_POP: begin
                            if (fault) begin
                                resp_data <= INDEF_W;
                            end else begin
                                resp_data <= rd0;
                                tag_word[{slot0, 1'b0} +: 2] <= TAG_EMPTY;
                                top <= slot0 + IDXW'(1);
                            end
                        end
                        OP_READ: resp_data <= fault ? INDEF_W : rdi;
                        OP_FREE: tag_word[{sloti, 1'b0} +: 2] <= TAG_EMPTY;
                        default: ;
                    endcase
                    if (fault) begin
                        sf <= 1'b1;
                        c1 <= (op_q == OP_PUSH);
                    end
                    resp_fault <= fault;
                    if (op_q == OP_XCHG && !fault) begin
                        tmp_q     <= rd0;
                        xchg_do_q <= xchg_do;
                        state     <= XCHG2;
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                XCHG2: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_reg_stack.sv
// Directed self-checking bench for fpu_reg_stack (DEPTH=8, WIDTH=80); honours FPU_STACK_TAGCLASS_EN.
module tb_fpu_reg_stack;
    localparam int unsigned WIDTH = 80;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IDXW  = 3;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, READ = 3'd3,
                           WRITE = 3'd4, XCHG = 3'd5, FREE = 3'd6, RSVD = 3'd7;
    localparam logic [79:0] ONE   = 80'h3FFF_8000000000000000;
    localparam logic [79:0] TWO   = 80'h4000_8000000000000000;
    localparam logic [79:0] THREE = 80'h4000_C000000000000000;
    localparam logic [79:0] FOUR  = 80'h4001_8000000000000000;
    localparam logic [79:0] INDEF = 80'hFFFF_C000000000000000;
    localparam logic [79:0] INF   = 80'h7FFF_8000000000000000;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [2:0]         cmd_op = 3'd0;
    logic [IDXW-1:0]    cmd_idx = '0;
    logic [WIDTH-1:0]   cmd_data = '0;
    logic               resp_valid;
    logic [WIDTH-1:0]   resp_data;
    logic               resp_fault;
    logic [IDXW-1:0]    top;
    logic [2*DEPTH-1:0] tag_word;
    logic               c1;
    logic               sf;

    int vectors = 0;
    int miscompares = 0;
    int ready_err = 0;
    int r_lat;
    logic r_ok;
    logic [WIDTH-1:0] r_data;
    logic r_fault;

    fpu_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW), .INDEF(INDEF)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
        .top(top), .tag_word(tag_word), .c1(c1), .sf(sf)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Holds the command until the response is seen; latency counts cycles after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [IDXW-1:0] idx, input logic [WIDTH-1:0] d);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_idx = idx; cmd_data = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        r_lat = 0; r_ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            r_lat++;
            if (cmd_ready !== 1'b0) ready_err++;
            if (resp_valid === 1'b1) begin r_ok = 1'b1; break; end
        end
        r_data = resp_data; r_fault = resp_fault;
        cmd_valid = 1'b0; cmd_op = NOP;
        if (!r_ok) begin
            vectors++; miscompares++;
            $display("FAIL resp_timeout op=%0d: resp_valid=0 required 1 within 10 cycles", op);
        end
    endtask

    task automatic test_reset();
        do_reset();
        issue(PUSH, 0, ONE);
        @(posedge clk); #3 reset = 1'b0; #1;
        vectors++; if (top !== 3'd0) begin miscompares++; $display("FAIL rst_top: got %0d want 0", top); end
        vectors++; if (tag_word !== 16'hFFFF) begin miscompares++; $display("FAIL rst_tags: got %h want ffff", tag_word); end
        vectors++; if ({sf, c1, resp_valid, resp_fault} !== 4'b0000) begin miscompares++; $display("FAIL rst_flags: got %b want 0000", {sf, c1, resp_valid, resp_fault}); end
        vectors++; if (resp_data !== '0) begin miscompares++; $display("FAIL rst_data: got %h want 0", resp_data); end
        @(negedge clk); reset = 1'b1; @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_push_read();
        do_reset();
        issue(PUSH, 0, ONE);
        vectors++; if ({r_lat, r_fault, top} !== {32'd2, 1'b0, 3'd7}) begin miscompares++; $display("FAIL push1: lat=%0d fault=%b top=%0d want 2/0/7", r_lat, r_fault, top); end
        issue(PUSH, 0, TWO);
        vectors++; if (top !== 3'd6) begin miscompares++; $display("FAIL push2_top: got %0d want 6", top); end
        issue(READ, 1, '0);
        vectors++; if ({r_lat, r_fault, r_data} !== {32'd2, 1'b0, ONE}) begin miscompares++; $display("FAIL read1: lat=%0d fault=%b data=%h want 2/0/%h", r_lat, r_fault, r_data, ONE); end
        vectors++; if (top !== 3'd6) begin miscompares++; $display("FAIL read1_top: got %0d want 6", top); end
        issue(READ, 0, '0);
        vectors++; if (r_data !== TWO) begin miscompares++; $display("FAIL read0: got %h want %h", r_data, TWO); end
        vectors++; if (tag_word !== 16'h0FFF) begin miscompares++; $display("FAIL push_tags: got %h want 0fff", tag_word); end
    endtask

    task automatic test_xchg();
        do_reset();
        issue(PUSH, 0, ONE); issue(PUSH, 0, TWO); issue(PUSH, 0, THREE); issue(PUSH, 0, FOUR);
        issue(XCHG, 2, '0);
        vectors++; if ({r_lat, r_fault} !== {32'd3, 1'b0}) begin miscompares++; $display("FAIL xchg: lat=%0d fault=%b want 3/0", r_lat, r_fault); end
        issue(READ, 0, '0);
        vectors++; if (r_data !== TWO) begin miscompares++; $display("FAIL xchg_st0: got %h want %h", r_data, TWO); end
        issue(READ, 2, '0);
        vectors++; if (r_data !== FOUR) begin miscompares++; $display("FAIL xchg_st2: got %h want %h", r_data, FOUR); end
        issue(READ, 1, '0);
        vectors++; if (r_data !== THREE) begin miscompares++; $display("FAIL xchg_st1: got %h want %h", r_data, THREE); end
        issue(XCHG, 0, '0);
        vectors++; if ({r_lat, r_fault} !== {32'd3, 1'b0}) begin miscompares++; $display("FAIL xchg0: lat=%0d fault=%b want 3/0", r_lat, r_fault); end
        issue(READ, 0, '0);
        vectors++; if (r_data !== TWO) begin miscompares++; $display("FAIL xchg0_st0: got %h want %h", r_data, TWO); end
        issue(XCHG, 5, '0);
        vectors++; if ({r_lat, r_fault, sf, c1} !== {32'd2, 1'b1, 1'b1, 1'b0}) begin miscompares++; $display("FAIL xchg_uf: lat=%0d fault=%b sf=%b c1=%b want 2/1/1/0", r_lat, r_fault, sf, c1); end
        issue(READ, 0, '0);
        vectors++; if (r_data !== TWO) begin miscompares++; $display("FAIL xchg_uf_st0: got %h want %h", r_data, TWO); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 8; k++) issue(PUSH, 0, {16'h4000, 64'h8000_0000_0000_0000 | 64'(k)});
        vectors++; if ({top, sf} !== {3'd0, 1'b0}) begin miscompares++; $display("FAIL ovf_fill: top=%0d sf=%b want 0/0", top, sf); end
        issue(PUSH, 0, ONE);
        vectors++; if ({r_fault, sf, c1, top} !== {1'b1, 1'b1, 1'b1, 3'd0}) begin miscompares++; $display("FAIL ovf: fault=%b sf=%b c1=%b top=%0d want 1/1/1/0", r_fault, sf, c1, top); end
        issue(READ, 0, '0);
        vectors++; if (r_data !== 80'h4000_8000000000000007) begin miscompares++; $display("FAIL ovf_st0: got %h want 40008000000000000007", r_data); end
        issue(READ, 7, '0);
        vectors++; if (r_data !== 80'h4000_8000000000000000) begin miscompares++; $display("FAIL ovf_st7: got %h want 40008000000000000000", r_data); end
    endtask

    task automatic test_underflow();
        do_reset();
        issue(POP, 0, '0);
        vectors++; if ({r_lat, r_fault, r_data, c1, sf, top} !== {32'd2, 1'b1, INDEF, 1'b0, 1'b1, 3'd0}) begin miscompares++; $display("FAIL pop_uf: lat=%0d fault=%b data=%h c1=%b sf=%b top=%0d", r_lat, r_fault, r_data, c1, sf, top); end
        issue(READ, 3, '0);
        vectors++; if ({r_fault, r_data} !== {1'b1, INDEF}) begin miscompares++; $display("FAIL read_uf: fault=%b data=%h want 1/%h", r_fault, r_data, INDEF); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] v;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            issue(PUSH, 0, {16'h4002, 64'hC000_0000_0000_0000 | 64'(k)});
            vectors++; if ({r_fault, top} !== {1'b0, 3'((8 - k) % 8)}) begin miscompares++; $display("FAIL wrap_push%0d: fault=%b top=%0d want 0/%0d", k, r_fault, top, (8 - k) % 8); end
        end
        for (int k = 1; k <= 8; k++) begin
            issue(POP, 0, '0);
            v = {16'h4002, 64'hC000_0000_0000_0000 | 64'(9 - k)};
            vectors++; if ({r_fault, r_data, top} !== {1'b0, v, 3'(k % 8)}) begin miscompares++; $display("FAIL wrap_pop%0d: fault=%b data=%h top=%0d want 0/%h/%0d", k, r_fault, r_data, top, v, k % 8); end
        end
        vectors++; if ({tag_word, sf} !== {16'hFFFF, 1'b0}) begin miscompares++; $display("FAIL wrap_tags: tags=%h sf=%b want ffff/0", tag_word, sf); end
    endtask

    task automatic test_write_free();
        do_reset();
        issue(WRITE, 3, THREE);
        vectors++; if ({r_fault, top, tag_word[7:6]} !== {1'b0, 3'd0, 2'b00}) begin miscompares++; $display("FAIL write: fault=%b top=%0d tag3=%b want 0/0/00", r_fault, top, tag_word[7:6]); end
        issue(READ, 3, '0);
        vectors++; if ({r_fault, r_data} !== {1'b0, THREE}) begin miscompares++; $display("FAIL write_rd: fault=%b data=%h want 0/%h", r_fault, r_data, THREE); end
        issue(FREE, 3, '0);
        vectors++; if ({r_fault, top, tag_word} !== {1'b0, 3'd0, 16'hFFFF}) begin miscompares++; $display("FAIL free: fault=%b top=%0d tags=%h want 0/0/ffff", r_fault, top, tag_word); end
        issue(READ, 3, '0);
        vectors++; if ({r_fault, r_data} !== {1'b1, INDEF}) begin miscompares++; $display("FAIL free_rd: fault=%b data=%h want 1/%h", r_fault, r_data, INDEF); end
        do_reset();
        issue(PUSH, 0, ONE);
        issue(NOP, 2, FOUR);
        vectors++; if ({r_lat, r_fault, top, tag_word} !== {32'd2, 1'b0, 3'd7, 16'h3FFF}) begin miscompares++; $display("FAIL nop: lat=%0d fault=%b top=%0d tags=%h", r_lat, r_fault, top, tag_word); end
        issue(RSVD, 1, FOUR);
        vectors++; if ({r_lat, r_fault, top, tag_word, sf} !== {32'd2, 1'b0, 3'd7, 16'h3FFF, 1'b0}) begin miscompares++; $display("FAIL rsvd: lat=%0d fault=%b top=%0d tags=%h sf=%b", r_lat, r_fault, top, tag_word, sf); end
    endtask

    task automatic test_tagclass();
        logic [1:0] tz, ts;
`ifdef FPU_STACK_TAGCLASS_EN
        tz = 2'b01; ts = 2'b10;
`else
        tz = 2'b00; ts = 2'b00;
`endif
        do_reset();
        issue(PUSH, 0, '0);
        vectors++; if (tag_word[15:14] !== tz) begin miscompares++; $display("FAIL tag_zero: got %b want %b", tag_word[15:14], tz); end
        issue(PUSH, 0, INF);
        vectors++; if (tag_word[13:12] !== ts) begin miscompares++; $display("FAIL tag_special: got %b want %b", tag_word[13:12], ts); end
    endtask

    task automatic test_reset_abort();
        int seen;
        do_reset();
        @(negedge clk);
        cmd_op = WRITE; cmd_idx = 0; cmd_data = ONE; cmd_valid = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        cmd_valid = 1'b0;
        seen = 0;
        repeat (2) begin @(negedge clk); if (resp_valid) seen++; end
        reset = 1'b1;
        repeat (4) begin @(negedge clk); if (resp_valid) seen++; end
        vectors++; if ({seen, tag_word} !== {32'd0, 16'hFFFF}) begin miscompares++; $display("FAIL abort: resp_seen=%0d tags=%h want 0/ffff", seen, tag_word); end
        issue(READ, 0, '0);
        vectors++; if ({r_fault, r_data} !== {1'b1, INDEF}) begin miscompares++; $display("FAIL abort_rd: fault=%b data=%h want 1/%h", r_fault, r_data, INDEF); end
    endtask

    task automatic test_handshake();
        vectors++; if (ready_err !== 0) begin miscompares++; $display("FAIL busy_ready: %0d busy cycles with cmd_ready!=0, want 0", ready_err); end
    endtask

    initial begin
        test_reset();
        test_push_read();
        test_xchg();
        test_overflow();
        test_underflow();
        test_wrap();
        test_write_free();
        test_tagclass();
        test_reset_abort();
        test_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
